vx_afu_axil_ctrl: RTL and testbench
===================================

VX_AFU_AXIL_CTRL -- requirements
Module: VX_afu_axil_ctrl

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 8, the control address width in bits.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, the control data width in bits; only 32 is legal.
REQ-003 SHALL have parameter NUM_ARGS, default 4, the number of 64-bit kernel argument registers; legal range 1..(2^AXI_ADDR_WIDTH-16)/8.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have ports s_axi_ctrl_awvalid/awready/awaddr[AXI_ADDR_WIDTH]/wvalid/wready/wdata[32]/wstrb[4]/bvalid/bready/bresp[2], the AXI4-Lite write channels (directions per AXI slave).
REQ-007 SHALL have ports s_axi_ctrl_arvalid/arready/araddr[AXI_ADDR_WIDTH]/rvalid/rready/rdata[32]/rresp[2], the AXI4-Lite read channels.
REQ-008 SHALL have port ap_start, output, 1 bit, the kernel start level.
REQ-009 SHALL have ports ap_done, ap_ready and ap_idle, each an input of 1 bit: done pulse, ready pulse and idle level.
REQ-010 SHALL have port args, output, NUM_ARGS*64 bits; argument i occupies bits [64i+63:64i].
REQ-011 SHALL have port interrupt, output, 1 bit, the level interrupt.

Function
REQ-012 SHALL use this register map: 0x00 CTRL; 0x04 GIE bit0; 0x08 IER bits[1:0]; 0x0C ISR bits[1:0]; 0x10+8i ARG i low word; 0x14+8i ARG i high word.
REQ-013 SHALL define the CTRL bits as: bit0 start (R/W1S), bit1 done (read-only, clear-on-read), bit2 idle (read-only, equal to ap_idle), bit3 ready (read-only, 1-cycle), bit7 auto_restart (R/W).
REQ-014 SHALL implement the write FSM as: WIDLE (awready=1, wready=1) -> WRESP once both AW and W have been accepted; AW and W may arrive in either order or in the same cycle, and the first one accepted is held with its ready deasserted until the other arrives.
REQ-015 SHALL, in WRESP, assert bvalid with bresp=00 and return to WIDLE on bready; register update takes effect in the cycle WRESP is entered.
REQ-016 SHALL honour wstrb per byte on ARG, GIE and IER registers; a CTRL write with wstrb[0]=0 has no effect.
REQ-017 SHALL implement the read FSM as: RIDLE (arready=1) -> RDATA on arvalid; rvalid=1 with rresp=00 holds rdata stable until rready, then returns to RIDLE; 1-cycle latency from AR handshake to rvalid.
REQ-018 SHALL silently drop writes to unmapped addresses and return 0 on reads of them, both with OKAY response; address bits [1:0] are ignored.
REQ-019 SHALL set ap_start on a CTRL write with wdata[0]=1; it clears on an ap_ready pulse unless auto_restart=1, in which case it stays set.
REQ-020 SHALL set the done bit on an ap_done pulse and clear it on the AR handshake of a CTRL read; a simultaneous set wins and the read returns the pre-set value.
REQ-021 SHALL set ISR[0] on ap_done when IER[0]=1 and ISR[1] on ap_ready when IER[1]=1; writing 1 to an ISR bit toggles it, and a set event in the same cycle wins.
REQ-022 SHALL drive interrupt = GIE & (ISR[0] | ISR[1]), registered with 1 cycle of latency.
REQ-023 SHALL present args directly from registers, with no staging.

Reset
REQ-024 SHALL, while reset is asserted, hold both FSMs idle and drive awready=wready=arready=0, bvalid=rvalid=0, rdata=0, ap_start=0, interrupt=0, args=0, and all registers and sticky bits 0.
REQ-025 SHALL abandon any transaction in flight when reset is asserted; after release, the readys assert on the first clock edge.

Verification
REQ-026 SHALL pass this scenario: write 0x10=0xDEADBEEF, then 0x14=0x01234567 -> args[63:0]=0x01234567DEADBEEF; read 0x14 returns 0x01234567.
REQ-027 SHALL pass this scenario: W then AW issued 3 cycles apart -> exactly one bvalid, and the register is updated only after AW arrives.
REQ-028 SHALL pass this scenario: write CTRL=0x01, then pulse ap_ready -> ap_start falls the next cycle; with CTRL=0x81 instead, ap_start stays 1.
REQ-029 SHALL pass this scenario: GIE=1, IER=1, pulse ap_done -> interrupt=1 one cycle later; CTRL read returns bit1=1, and a second read returns bit1=0; writing ISR=1 drops interrupt.
REQ-030 SHALL pass this scenario: write 0x18 with wstrb=0b0010 and wdata=0xAABBCCDD -> ARG1 low word=0x0000CC00; a read of unmapped address 0xFC returns 0 with OKAY response.
REQ-031 SHALL pass this scenario: assert reset with rvalid pending -> rvalid=0 immediately, and all args read back 0 after release.

Source files
------------

// File: rtl/vx_afu_axil_ctrl.sv
// AXI4-Lite control slave for an accelerator kernel: start/done/idle/ready
// handshake, interrupt enable/status registers and NUM_ARGS 64-bit arguments.
module vx_afu_axil_ctrl #(
  parameter int unsigned AXI_ADDR_WIDTH = 8,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_ARGS       = 4
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          s_axi_ctrl_awvalid,
  output logic                          s_axi_ctrl_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ctrl_awaddr,
  input  logic                          s_axi_ctrl_wvalid,
  output logic                          s_axi_ctrl_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
  output logic                          s_axi_ctrl_bvalid,
  input  logic                          s_axi_ctrl_bready,
  output logic [1:0]                    s_axi_ctrl_bresp,

  input  logic                          s_axi_ctrl_arvalid,
  output logic                          s_axi_ctrl_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ctrl_araddr,
  output logic                          s_axi_ctrl_rvalid,
  input  logic                          s_axi_ctrl_rready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
  output logic [1:0]                    s_axi_ctrl_rresp,

  output logic                          ap_start,
  input  logic                          ap_done,
  input  logic                          ap_ready,
  input  logic                          ap_idle,
  output logic [NUM_ARGS*64-1:0]        args,
  output logic                          interrupt
);

  localparam int unsigned AW = AXI_ADDR_WIDTH;
  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  localparam logic [AW-1:0] ADDR_CTRL = AW'(32'h00);
  localparam logic [AW-1:0] ADDR_GIE  = AW'(32'h04);
  localparam logic [AW-1:0] ADDR_IER  = AW'(32'h08);
  localparam logic [AW-1:0] ADDR_ISR  = AW'(32'h0C);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(32'h3);

  typedef enum logic {WIDLE, WRESP} wstate_t;
  typedef enum logic {RIDLE, RDATA} rstate_t;

  wstate_t wstate, wstate_next;
  rstate_t rstate, rstate_next;

  logic          ready_en;
  logic          aw_got, w_got;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic          aw_hs, w_hs, ar_hs, wr_fire;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_val;
  logic [SW-1:0] wr_strb;
  logic          wr_ctrl, wr_gie, wr_ier, wr_isr, rd_ctrl_hs;

  logic          auto_restart, done_bit, gie;
  logic [1:0]    ier, isr;

  // Readys come up on the first edge after reset release, not combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign s_axi_ctrl_awready = ready_en & (wstate == WIDLE) & ~aw_got;
  assign s_axi_ctrl_wready  = ready_en & (wstate == WIDLE) & ~w_got;
  assign s_axi_ctrl_bvalid  = (wstate == WRESP);
  assign s_axi_ctrl_bresp   = 2'b00;

  assign aw_hs   = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
  assign w_hs    = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
  assign wr_fire = (wstate == WIDLE) & (aw_got | aw_hs) & (w_got | w_hs);

  // Whichever half arrived first is replayed from its holding register.
  assign wr_addr = (aw_got ? awaddr_q : s_axi_ctrl_awaddr) & WORD_MASK;
  assign wr_data = w_got ? wdata_q : s_axi_ctrl_wdata;
  assign wr_strb = w_got ? wstrb_q : s_axi_ctrl_wstrb;

  assign wr_ctrl = wr_fire & (wr_addr == ADDR_CTRL);
  assign wr_gie  = wr_fire & (wr_addr == ADDR_GIE);
  assign wr_ier  = wr_fire & (wr_addr == ADDR_IER);
  assign wr_isr  = wr_fire & (wr_addr == ADDR_ISR);

  always_comb begin
    wstate_next = wstate;
    case (wstate)
      WIDLE: if (wr_fire) wstate_next = WRESP;
      WRESP: if (s_axi_ctrl_bready) wstate_next = WIDLE;
      default: wstate_next = WIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate   <= WIDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wstate <= wstate_next;
      if (wr_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          awaddr_q <= s_axi_ctrl_awaddr;
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= s_axi_ctrl_wdata;
          wstrb_q <= s_axi_ctrl_wstrb;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_bit     <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      interrupt    <= 1'b0;
    end else begin
      if (wr_ctrl & wr_strb[0] & wr_data[0]) ap_start <= 1'b1;
      else if (ap_ready & ~auto_restart)     ap_start <= 1'b0;
      if (wr_ctrl & wr_strb[0]) auto_restart <= wr_data[7];
      if (ap_done)         done_bit <= 1'b1;
      else if (rd_ctrl_hs) done_bit <= 1'b0;
      if (wr_gie & wr_strb[0]) gie <= wr_data[0];
      if (wr_ier & wr_strb[0]) ier <= wr_data[1:0];
      isr <= (isr ^ ((wr_isr & wr_strb[0]) ? wr_data[1:0] : 2'b00))
           | {ap_ready & ier[1], ap_done & ier[0]};
      interrupt <= gie & (|isr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      args <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_ARGS; i++) begin
        for (int unsigned b = 0; b < SW; b++) begin
          if (wr_strb[b] && wr_addr == AW'(16 + 8*i))
            args[64*i + 8*b +: 8] <= wr_data[8*b +: 8];
          if (wr_strb[b] && wr_addr == AW'(20 + 8*i))
            args[64*i + 32 + 8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign s_axi_ctrl_arready = ready_en & (rstate == RIDLE);
  assign s_axi_ctrl_rvalid  = (rstate == RDATA);
  assign s_axi_ctrl_rresp   = 2'b00;
  assign ar_hs      = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
  assign rd_addr    = s_axi_ctrl_araddr & WORD_MASK;
  assign rd_ctrl_hs = ar_hs & (rd_addr == ADDR_CTRL);

  always_comb begin
    rd_val = '0;
    if (rd_addr == ADDR_CTRL) begin
      rd_val[0] = ap_start;
      rd_val[1] = done_bit;
      rd_val[2] = ap_idle;
      rd_val[3] = ap_ready;
      rd_val[7] = auto_restart;
    end
    if (rd_addr == ADDR_GIE) rd_val[0]   = gie;
    if (rd_addr == ADDR_IER) rd_val[1:0] = ier;
    if (rd_addr == ADDR_ISR) rd_val[1:0] = isr;
    for (int unsigned i = 0; i < NUM_ARGS; i++) begin
      if (rd_addr == AW'(16 + 8*i)) rd_val = args[64*i +: 32];
      if (rd_addr == AW'(20 + 8*i)) rd_val = args[64*i + 32 +: 32];
    end
  end

  always_comb begin
    rstate_next = rstate;
    case (rstate)
      RIDLE: if (ar_hs) rstate_next = RDATA;
      RDATA: if (s_axi_ctrl_rready) rstate_next = RIDLE;
      default: rstate_next = RIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate           <= RIDLE;
      s_axi_ctrl_rdata <= '0;
    end else begin
      rstate <= rstate_next;
      if (ar_hs) s_axi_ctrl_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_vx_afu_axil_ctrl.sv
// Scoreboard bench for vx_afu_axil_ctrl: read expectations queued at AR issue,
// popped on R handshake; side-band outputs checked against bench constants.
module tb_vx_afu_axil_ctrl;
  localparam int unsigned NARGS = 4;

  logic clk = 1'b0;
  logic reset;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic ap_start, ap_done, ap_ready, ap_idle, interrupt;
  logic [NARGS*64-1:0] args;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  vx_afu_axil_ctrl #(.AXI_ADDR_WIDTH(8), .AXI_DATA_WIDTH(32), .NUM_ARGS(NARGS)) dut (
    .clk(clk), .reset(reset),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready), .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wready(wready), .s_axi_ctrl_wdata(wdata),
    .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bready(bready),
    .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
    .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp),
    .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .args(args), .interrupt(interrupt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_b();
    int n = 0;
    logic got = 1'b0;
    bready = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1'b1;
        chk("bresp", 64'(bresp), 64'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0;
    if (!got) chk("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    int n = 0;
    logic aw_done = 1'b0, w_done = 1'b0, aw_ok, w_ok;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 30) begin
      awvalid = !aw_done && n >= aw_dly;
      wvalid  = !w_done && n >= w_dly;
      @(negedge clk);
      aw_ok = awvalid & awready;
      w_ok  = wvalid & wready;
      @(posedge clk); #1;
      if (aw_ok) aw_done = 1'b1;
      if (w_ok)  w_done  = 1'b1;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("aw_w_timeout", 64'd0, 64'd1);
    wait_b();
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] e, input string tag, input int rdly);
    int n = 0;
    logic ok, got = 1'b0;
    exp_q.push_back(e);
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1;
      if (ok) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      arvalid = 1'b0;
      chk("ar_timeout", 64'd0, 64'd1);
    end
    chk("r_latency", 64'(rvalid), 64'd1);
    repeat (rdly) @(posedge clk);
    #1 rready = 1'b1;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (rvalid) begin
        got = 1'b1;
        chk("rresp", 64'(rresp), 64'd0);
        if (exp_q.size() > 0) chk(tag, 64'(rdata), 64'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    if (!got) chk("r_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse(input int which);
    if (which == 0) ap_done = 1'b1; else ap_ready = 1'b1;
    @(posedge clk); #1;
    ap_done = 1'b0; ap_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bcnt;
    logic ok;
    reset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    ap_done = 0; ap_ready = 0; ap_idle = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_ap_start", 64'(ap_start), 64'd0);
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    chk("rst_args", 64'(|args), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_wready", 64'(wready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);

    // 64-bit argument assembly from two word writes
    axi_write(8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_write(8'h14, 32'h01234567, 4'hF, 0, 0);
    chk("arg0", args[63:0], 64'h01234567DEADBEEF);
    axi_read(8'h14, 32'h01234567, "rd_arg0_hi", 0);
    axi_read(8'h10, 32'hDEADBEEF, "rd_arg0_lo", 2);
    axi_read(8'h17, 32'h01234567, "rd_arg0_hi_unaligned", 0);
    axi_write(8'h2C, 32'hCAFEF00D, 4'hF, 2, 0);
    chk("arg3_aw_first", args[255:192], 64'hCAFEF00D_00000000);

    // W leads AW by three cycles
    awaddr = 8'h20; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); ok = wready;
    @(posedge clk); #1; wvalid = 1'b0;
    chk("w_first_accepted", 64'(ok), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("w_held_wready", 64'(wready), 64'd0);
      chk("arg2_before_aw", args[191:128], 64'd0);
      chk("no_b_before_aw", 64'(bvalid), 64'd0);
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(negedge clk); ok = awready;
    @(posedge clk); #1; awvalid = 1'b0;
    chk("aw_late_accepted", 64'(ok), 64'd1);
    chk("arg2_after_aw", args[191:128], 64'h55AA55AA);
    bready = 1'b1; bcnt = 0;
    repeat (6) begin
      @(negedge clk); if (bvalid) bcnt++;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    chk("b_count", 64'(bcnt), 64'd1);

    // start / auto_restart
    axi_write(8'h00, 32'h00000001, 4'h0, 0, 0);
    chk("ctrl_strb0_ignored", 64'(ap_start), 64'd0);
    axi_write(8'h00, 32'h00000001, 4'hF, 0, 0);
    chk("ap_start_set", 64'(ap_start), 64'd1);
    pulse(1);
    chk("ap_start_cleared", 64'(ap_start), 64'd0);
    axi_write(8'h00, 32'h00000081, 4'hF, 0, 0);
    pulse(1);
    chk("ap_start_autorestart", 64'(ap_start), 64'd1);
    axi_read(8'h00, 32'h00000085, "rd_ctrl_autorestart", 0);
    axi_write(8'h00, 32'h00000000, 4'hF, 0, 0);
    chk("ap_start_w1s", 64'(ap_start), 64'd1);
    pulse(1);
    chk("ap_start_cleared2", 64'(ap_start), 64'd0);

    // done / interrupt
    axi_write(8'h04, 32'h00000001, 4'hF, 0, 0);
    axi_write(8'h08, 32'h00000001, 4'hF, 0, 0);
    axi_read(8'h0C, 32'h00000000, "rd_isr_idle", 0);
    pulse(0);
    chk("irq_not_yet", 64'(interrupt), 64'd0);
    @(posedge clk); #1;
    chk("irq_set", 64'(interrupt), 64'd1);
    axi_read(8'h00, 32'h00000006, "rd_ctrl_done", 0);
    axi_read(8'h00, 32'h00000004, "rd_ctrl_done_cleared", 0);
    axi_read(8'h0C, 32'h00000001, "rd_isr_set", 0);
    axi_write(8'h0C, 32'h00000001, 4'hF, 0, 0);
    chk("irq_cleared", 64'(interrupt), 64'd0);
    pulse(1);
    axi_read(8'h0C, 32'h00000000, "rd_isr_ready_masked", 0);
    axi_read(8'h08, 32'h00000001, "rd_ier", 0);

    // byte strobes and unmapped addresses
    axi_write(8'h18, 32'hAABBCCDD, 4'b0010, 0, 0);
    chk("arg1_strb", args[127:64], 64'h0000CC00);
    axi_read(8'h18, 32'h0000CC00, "rd_arg1_strb", 0);
    axi_write(8'hFC, 32'h12345678, 4'hF, 0, 0);
    axi_read(8'hFC, 32'h00000000, "rd_unmapped", 0);
    axi_read(8'h10, 32'hDEADBEEF, "rd_arg0_after_unmapped", 0);

    // reset with a read response pending
    axi_write(8'h00, 32'h00000001, 4'hF, 0, 0);
    axi_write(8'h0C, 32'h00000002, 4'hF, 0, 0);
    araddr = 8'h10; arvalid = 1'b1;
    @(negedge clk); ok = arready;
    @(posedge clk); #1; arvalid = 1'b0;
    chk("pending_ar", 64'(ok), 64'd1);
    chk("pending_rvalid", 64'(rvalid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rvalid", 64'(rvalid), 64'd0);
    chk("async_rdata", 64'(rdata), 64'd0);
    chk("async_args", 64'(|args), 64'd0);
    chk("async_ap_start", 64'(ap_start), 64'd0);
    chk("async_arready", 64'(arready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_interrupt", 64'(interrupt), 64'd0);
    for (int unsigned i = 0; i < 2*NARGS; i++)
      axi_read(8'(16 + 4*i), 32'h0, "rd_arg_after_reset", 0);
    axi_read(8'h0C, 32'h00000000, "rd_isr_after_reset", 0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
